manual_value_ctrl: RTL and testbench
====================================

# manual_value_ctrl

Clocked, parametrised successor to the button-driven angle controls (theta/phi). It turns two active-low push-buttons into a bounded signed value with debounce, single-step on press, auto-repeat on hold, and selectable wrap or saturate at the bounds. It sits between the board buttons and the modulator/controller parameter inputs. The seven-segment formatting stays downstream of `o_value`.

## Interface
Parameters:
- `WIDTH`, 16: bit width of the signed value.
- `MIN`, 30: lower bound, signed, inclusive.
- `MAX`, 180: upper bound, signed, inclusive. `MIN < MAX` is required.
- `V0`, 180: reset value, with `MIN ≤ V0 ≤ MAX`.
- `STEP`, 5: increment per step, positive, `≤ MAX-MIN`.
- `WRAP`, 1: 1 wraps to the opposite bound when a step crosses a bound; 0 saturates at the bound.
- `DEBOUNCE_CYC`, 50000: consecutive stable cycles required before a button state is accepted.
- `REPEAT_DELAY`, 25000000: hold cycles before auto-repeat starts. 0 disables auto-repeat.
- `REPEAT_PERIOD`, 5000000: cycles between repeated steps while held.

Ports:
- `i_clock`, in, 1: system clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_increase`, in, 1: button, active-low, asynchronous to `i_clock`.
- `i_decrease`, in, 1: button, active-low, asynchronous to `i_clock`.
- `o_value`, out, WIDTH: current value, signed, registered.
- `o_step`, out, 1: one-cycle pulse in the cycle `o_value` changes.
- `o_at_min`, out, 1: high when `o_value == MIN`.
- `o_at_max`, out, 1: high when `o_value == MAX`.

## Operation
- Each button path: 2-FF synchroniser, inversion to active-high, then debounce.
- Debounce: the accepted state changes only after the synchronised input differs from it for `DEBOUNCE_CYC` consecutive cycles. Any glitch back restarts the count.
- Per-button FSM with states IDLE, PRESSED and REPEAT:
  - IDLE → PRESSED on the debounced rising edge. This emits one step request.
  - PRESSED → REPEAT after `REPEAT_DELAY` cycles held, if `REPEAT_DELAY > 0`. This emits a request on entry.
  - REPEAT emits a request every `REPEAT_PERIOD` cycles.
  - Any state → IDLE on debounced release. The hold and repeat counters clear.
- Arbitration: if up and down requests fall in the same cycle, both are dropped. `o_value` does not change and `o_step` stays 0.
- Arithmetic is done in WIDTH+1 bits so the sum cannot overflow.
  - Up: `n = v + STEP`. If `n > MAX`, the result is `MIN` when WRAP=1, else `MAX`.
  - Down: `n = v - STEP`. If `n < MIN`, the result is `MAX` when WRAP=1, else `MIN`.
- `o_step` pulses only when the new value differs from the old one. A saturated press at the bound gives no pulse.
- While one button is held, the other button's FSM runs independently. Its requests are subject to the arbitration rule above.

## Timing
- Reset values:
  - `o_value = V0`, `o_step = 0`.
  - `o_at_min`/`o_at_max` reflect V0.
  - Synchroniser flops = 0 (released), debounced states = released, FSMs = IDLE, all counters = 0.
- Reset mid-hold: the value returns to V0 immediately. After deassert, a still-pressed button must be re-debounced and produces a fresh press step.
- Press latency: the synchronised input appears 2 cycles after the pin falls. The debounced state rises `DEBOUNCE_CYC` cycles after that. The request is issued in the same cycle, and `o_value`/`o_step` update on the next edge. Total: 2 + DEBOUNCE_CYC + 1 cycles.
- Auto-repeat: the first repeat comes `REPEAT_DELAY` cycles after the debounced press, then every `REPEAT_PERIOD` cycles. Each repeat updates `o_value` 1 cycle after its request.
- `o_at_min`/`o_at_max` are combinational from the `o_value` register.

## Structure
- Shared package `manual_ctrl_pkg` holds:
  - FSM state encoding (IDLE/PRESSED/REPEAT).
  - A `clog2` helper for counter widths.
- Sub-module `button_debounce`: synchroniser, debounce counter and per-button FSM. Output is a one-cycle step request. It is instantiated twice.
- The top level holds the arbitration, bounds arithmetic and output register.

## Test plan
Sim parameters for all scenarios: DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, MIN=30, MAX=180, V0=180, STEP=5.

- Reset and single step: assert then release reset → `o_value`=180, `o_at_max`=1. Hold `i_decrease` low 10 cycles → exactly one `o_step`, `o_value`=175, on cycle 7 after the falling edge.
- Bounce rejection: toggle `i_increase` every 2 cycles for 40 cycles → no `o_step`, `o_value` unchanged.
- Wrap vs saturate:
  - WRAP=1, at 180, press up → 30.
  - WRAP=1, at 30, press down → 180.
  - WRAP=0, at 180, press up → stays 180 with no `o_step`.
- Auto-repeat: hold `i_decrease` 60 cycles from 180 → steps at debounced press +0, +20, +28, +36, +44, +52. Final value 150.
- Simultaneous press: both buttons fall in the same cycle → no value change, no `o_step`. Release both, then press up alone → +5.
- Async reset during a repeat hold → `o_value`=180 immediately, no `o_step`. Keep the button held through deassert → a new step appears 2+4+1 cycles after reset release.

Source files
------------

// File: rtl/manual_value_ctrl_pkg.sv
// Shared definitions for the manual value control: button FSM encoding
// and a width helper used to size the debounce and hold counters.
package manual_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } btn_state_t;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int clog2(input longint v);
    int     r;
    longint t;
    r = 0;
    t = 1;
    while (t < v) begin
      t = t << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/manual_value_ctrl_button_debounce.sv
// One push-button path: 2-FF synchroniser (inverting to active-high),
// consecutive-cycle debounce, and an IDLE/PRESSED/REPEAT FSM that issues
// one-cycle step requests on press and during auto-repeat.
module button_debounce
  import manual_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_button,
  output logic o_request
);

  localparam int DB_W_RAW = clog2(longint'(DEBOUNCE_CYC) + 1);
  localparam int DB_W     = (DB_W_RAW < 1) ? 1 : DB_W_RAW;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W_RAW = clog2(longint'(HOLD_MAX) + 1);
  localparam int HOLD_W   = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;

  localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] DELAY_V  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] PERIOD_V = HOLD_W'(REPEAT_PERIOD);

  logic              meta_p0;
  logic              sync_p1;
  logic              deb_q;
  logic [DB_W-1:0]   db_cnt;
  btn_state_t        state_q, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  // Two-stage synchroniser; the pin is active-low, stored pressed = 1.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= ~i_button;
      sync_p1 <= meta_p0;
    end
  end

  // Accept a new level only after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      deb_q  <= 1'b0;
      db_cnt <= '0;
    end else if (sync_p1 != deb_q) begin
      if (db_cnt == DB_LAST) begin
        deb_q  <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // FSM state and hold/repeat counter register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next state, counter and request; the counter holds cycles since the
  // last request so a compare against the delay/period fires the next one.
  always_comb begin
    state_nxt = state_q;
    hold_nxt  = hold_cnt;
    o_request = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_nxt = '0;
        if (deb_q) begin
          state_nxt = ST_PRESSED;
          hold_nxt  = HOLD_ONE;
          o_request = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!deb_q) begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (hold_cnt == DELAY_V) begin
            state_nxt = ST_REPEAT;
            hold_nxt  = HOLD_ONE;
            o_request = 1'b1;
          end else begin
            hold_nxt = hold_cnt + HOLD_ONE;
          end
        end
      end
      ST_REPEAT: begin
        if (!deb_q) begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end else if (hold_cnt == PERIOD_V) begin
          hold_nxt  = HOLD_ONE;
          o_request = 1'b1;
        end else begin
          hold_nxt = hold_cnt + HOLD_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

endmodule

// File: rtl/manual_value_ctrl.sv
// Two active-low buttons drive a bounded signed value: each button has its
// own debounce/repeat path, simultaneous requests cancel, and steps past a
// bound either wrap to the other bound or saturate.
module manual_value_ctrl
  import manual_ctrl_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int MIN           = 30,
  parameter int MAX           = 180,
  parameter int V0            = 180,
  parameter int STEP          = 5,
  parameter int WRAP          = 1,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_increase,
  input  logic             i_decrease,
  output logic [WIDTH-1:0] o_value,
  output logic             o_step,
  output logic             o_at_min,
  output logic             o_at_max
);

  localparam int EXT_W = WIDTH + 1;

  localparam logic signed [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
  localparam logic signed [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic signed [WIDTH-1:0] V0_V   = WIDTH'(V0);
  localparam logic signed [EXT_W-1:0] MIN_X  = EXT_W'(MIN);
  localparam logic signed [EXT_W-1:0] MAX_X  = EXT_W'(MAX);
  localparam logic signed [EXT_W-1:0] STEP_X = EXT_W'(STEP);

  logic                    req_up_p0;
  logic                    req_dn_p0;
  logic signed [WIDTH-1:0] value_p1;
  logic signed [WIDTH-1:0] next_value;
  logic                    step_p1;
  logic signed [EXT_W-1:0] value_x;
  logic signed [EXT_W-1:0] up_sum;
  logic signed [EXT_W-1:0] dn_sum;

  // Resolve an upward step that may have crossed MAX.
  function automatic logic signed [WIDTH-1:0] bound_up(input logic signed [EXT_W-1:0] sum);
    if (sum > MAX_X) begin
      if (WRAP != 0) bound_up = MIN_V;
      else           bound_up = MAX_V;
    end else begin
      bound_up = sum[WIDTH-1:0];
    end
  endfunction

  // Resolve a downward step that may have crossed MIN.
  function automatic logic signed [WIDTH-1:0] bound_dn(input logic signed [EXT_W-1:0] sum);
    if (sum < MIN_X) begin
      if (WRAP != 0) bound_dn = MAX_V;
      else           bound_dn = MIN_V;
    end else begin
      bound_dn = sum[WIDTH-1:0];
    end
  endfunction

  button_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_up (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_button (i_increase),
    .o_request(req_up_p0)
  );

  button_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_dn (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_button (i_decrease),
    .o_request(req_dn_p0)
  );

  // Sums are one bit wider than the value so they never overflow.
  assign value_x = {value_p1[WIDTH-1], value_p1};
  assign up_sum  = value_x + STEP_X;
  assign dn_sum  = value_x - STEP_X;

  // Single-direction request wins; both at once are dropped.
  always_comb begin
    next_value = value_p1;
    if (req_up_p0 && !req_dn_p0)      next_value = bound_up(up_sum);
    else if (req_dn_p0 && !req_up_p0) next_value = bound_dn(dn_sum);
  end

  // ---- stage p1: value register and change pulse ----
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      value_p1 <= V0_V;
      step_p1  <= 1'b0;
    end else begin
      value_p1 <= next_value;
      step_p1  <= (next_value != value_p1);
    end
  end

  assign o_value  = value_p1;
  assign o_step   = step_p1;
  assign o_at_min = (value_p1 == MIN_V);
  assign o_at_max = (value_p1 == MAX_V);

endmodule

// File: tb/tb_manual_value_ctrl.sv
// Bench for manual_value_ctrl: a wrapping and a saturating instance share
// the same button pins; a cycle-level reference model of the button
// behaviour predicts both values every clock.
module tb_manual_value_ctrl;

  localparam int DB    = 4;
  localparam int RD    = 20;
  localparam int RP    = 8;
  localparam int VMIN  = 30;
  localparam int VMAX  = 180;
  localparam int VINIT = 180;
  localparam int STP   = 5;

  logic        clk;
  logic        rst;
  logic        inc_n;
  logic        dec_n;
  logic [15:0] value_w, value_s;
  logic        step_w, step_s;
  logic        at_min_w, at_min_s;
  logic        at_max_w, at_max_s;

  int n_tests;
  int n_fail;
  int cyc;

  // Reference model state; index 0 = wrapping instance, 1 = saturating.
  int       m_val[2];
  bit       m_stp[2];
  // Per button; index 0 = increase, 1 = decrease.
  bit       m_p1[2];
  bit       m_sy[2];
  bit [DB-1:0] m_hist[2];
  int       m_nh[2];
  bit       m_deb[2];
  int       m_held[2];
  bit       m_req[2];

  manual_value_ctrl #(
    .WIDTH(16), .MIN(VMIN), .MAX(VMAX), .V0(VINIT), .STEP(STP), .WRAP(1),
    .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_w (
    .i_clock(clk), .i_reset(rst), .i_increase(inc_n), .i_decrease(dec_n),
    .o_value(value_w), .o_step(step_w), .o_at_min(at_min_w), .o_at_max(at_max_w)
  );

  manual_value_ctrl #(
    .WIDTH(16), .MIN(VMIN), .MAX(VMAX), .V0(VINIT), .STEP(STP), .WRAP(0),
    .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_s (
    .i_clock(clk), .i_reset(rst), .i_increase(inc_n), .i_decrease(dec_n),
    .o_value(value_s), .o_step(step_s), .o_at_min(at_min_s), .o_at_max(at_max_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i]  = VINIT;
      m_stp[i]  = 1'b0;
      m_p1[i]   = 1'b0;
      m_sy[i]   = 1'b0;
      m_hist[i] = '0;
      m_nh[i]   = 0;
      m_deb[i]  = 1'b0;
      m_held[i] = 0;
      m_req[i]  = 1'b0;
    end
  endtask

  // One clock edge of the model: apply last cycle's requests, then advance
  // each button's pipeline, debounce and hold time.
  task automatic model_edge();
    int  n;
    bit  rose;
    bit  pressed;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_req[0] != m_req[1]) begin
        n = m_val[i] + (m_req[0] ? STP : -STP);
        if (n > VMAX) n = (i == 0) ? VMIN : VMAX;
        if (n < VMIN) n = (i == 0) ? VMAX : VMIN;
        m_stp[i] = (n != m_val[i]);
        m_val[i] = n;
      end else begin
        m_stp[i] = 1'b0;
      end
    end
    for (int b = 0; b < 2; b++) begin
      pressed   = (b == 0) ? ~inc_n : ~dec_n;
      m_hist[b] = {m_hist[b][DB-2:0], m_sy[b]};
      if (m_nh[b] < DB) m_nh[b]++;
      m_sy[b] = m_p1[b];
      m_p1[b] = pressed;
      rose    = 1'b0;
      if (m_nh[b] >= DB && m_hist[b] == (m_deb[b] ? {DB{1'b0}} : {DB{1'b1}})) begin
        m_deb[b]  = ~m_deb[b];
        rose      = m_deb[b];
        m_held[b] = 0;
      end else if (m_deb[b]) begin
        m_held[b]++;
      end
      m_req[b] = m_deb[b] && (rose || (m_held[b] >= RD && (m_held[b] - RD) % RP == 0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("value_wrap", $signed(value_w), m_val[0]);
    chk("value_sat",  $signed(value_s), m_val[1]);
    chk("step_wrap",  step_w, m_stp[0]);
    chk("step_sat",   step_s, m_stp[1]);
    chk("at_min_wrap", at_min_w, m_val[0] == VMIN);
    chk("at_max_wrap", at_max_w, m_val[0] == VMAX);
    chk("at_min_sat",  at_min_s, m_val[1] == VMIN);
    chk("at_max_sat",  at_max_s, m_val[1] == VMAX);
  endtask

  // Hold one button (0 up, 1 down, 2 both) for `len` cycles, release for
  // `rel` cycles, and report how many steps each instance produced.
  task automatic press(input int which, input int len, input int rel, output int sw, output int ss);
    sw = 0;
    ss = 0;
    inc_n = !(which == 0 || which == 2);
    dec_n = !(which == 1 || which == 2);
    repeat (len) begin
      tick();
      sw += int'(step_w);
      ss += int'(step_s);
    end
    inc_n = 1'b1;
    dec_n = 1'b1;
    repeat (rel) begin
      tick();
      sw += int'(step_w);
      ss += int'(step_s);
    end
  endtask

  int sw, ss, first, k;
  int rep_at[$];
  int exp_at[6] = '{7, 27, 35, 43, 51, 59};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    inc_n   = 1'b1;
    dec_n   = 1'b1;
    model_reset();

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_value", $signed(value_w), 180);
    chk("reset_at_max", at_max_w, 1);
    chk("reset_at_min", at_min_w, 0);
    chk("reset_step", step_w, 0);
    repeat (3) tick();

    // Single step: exactly one pulse, seven cycles after the pin falls
    dec_n = 1'b0;
    sw = 0;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step_w) begin
        sw++;
        if (first < 0) first = i;
      end
    end
    chk("single_step_count", sw, 1);
    chk("single_step_cycle", first, 7);
    chk("single_step_value", $signed(value_w), 175);
    dec_n = 1'b1;
    repeat (10) tick();

    // Bounce rejection: toggle every 2 cycles for 40 cycles
    sw = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) inc_n = ~inc_n;
      tick();
      sw += int'(step_w);
    end
    inc_n = 1'b1;
    repeat (10) tick();
    chk("bounce_steps", sw, 0);
    chk("bounce_value", $signed(value_w), 175);

    // Wrap versus saturate at the bounds
    press(0, 10, 10, sw, ss);
    chk("up_to_max_wrap", $signed(value_w), 180);
    chk("up_to_max_sat", $signed(value_s), 180);
    press(0, 10, 10, sw, ss);
    chk("wrap_over_max", $signed(value_w), 30);
    chk("sat_at_max", $signed(value_s), 180);
    chk("sat_at_max_no_step", ss, 0);
    chk("wrap_at_min_flag", at_min_w, 1);
    press(1, 10, 10, sw, ss);
    chk("wrap_under_min", $signed(value_w), 180);
    chk("sat_down", $signed(value_s), 175);

    // Auto-repeat: steps at press +0, +20, +28, +36, +44, +52
    dec_n = 1'b0;
    rep_at.delete();
    for (int i = 1; i <= 75; i++) begin
      if (i == 61) dec_n = 1'b1;
      tick();
      if (step_w) rep_at.push_back(i);
    end
    chk("repeat_count", rep_at.size(), 6);
    k = (rep_at.size() < 6) ? rep_at.size() : 6;
    for (int i = 0; i < k; i++) chk("repeat_cycle", rep_at[i], exp_at[i]);
    chk("repeat_final_wrap", $signed(value_w), 150);
    chk("repeat_final_sat", $signed(value_s), 145);

    // Simultaneous press cancels, then a lone up press steps
    press(2, 10, 15, sw, ss);
    chk("both_no_step", sw + ss, 0);
    chk("both_value", $signed(value_w), 150);
    press(0, 10, 15, sw, ss);
    chk("up_after_both", $signed(value_w), 155);
    chk("up_after_both_steps", sw, 1);

    // Randomised button activity against the model
    for (int s = 0; s < 60; s++) begin
      k = int'($urandom_range(0, 4));
      inc_n = !(k == 1 || k == 3);
      dec_n = !(k == 2 || k == 3);
      if (k == 4) begin
        for (int i = 0; i < int'($urandom_range(2, 12)); i++) begin
          inc_n = $urandom_range(0, 1) != 0;
          dec_n = $urandom_range(0, 1) != 0;
          tick();
        end
      end else begin
        repeat (int'($urandom_range(1, 45))) tick();
      end
    end
    inc_n = 1'b1;
    dec_n = 1'b1;
    repeat (12) tick();

    // Asynchronous reset during a repeat hold, button kept pressed
    dec_n = 1'b0;
    repeat (40) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_reset_value_wrap", $signed(value_w), 180);
    chk("async_reset_value_sat", $signed(value_s), 180);
    chk("async_reset_step", step_w, 0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      tick();
      if (step_w) first = i;
    end
    chk("post_reset_step_cycle", first, 7);
    chk("post_reset_value", $signed(value_w), 175);
    dec_n = 1'b1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
